// File: rtl/bb_pkg.sv
// Shared definitions for the bb register-bank skid stage: state encoding
// (main valid in bit 0, skid valid in bit 1) and the handshake fire helper.
package bb_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } bbState_e;

  function automatic logic fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/bb_skid_slot.sv
// One data register of the skid stage: load enable, synchronous clear to
// RST_VAL and asynchronous active-high reset.
module bb_skid_slot #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  // Clear wins over load so a flush never lets a same-cycle beat in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
    end else if (clr_i) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/bb_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered in_ready and a
// synchronous flush; out_data always comes straight from the main slot.
module bb_skid_buffer
  import bb_pkg::*;
#(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  bbState_e      state_q, state_d;
  logic          inReady_q, inReady_d;
  logic          inFire, outFire;
  logic          mainLoad, mainFromSkid, skidLoad;
  logic [DW-1:0] mainData, skidData, mainD;

  assign out_valid_o = state_q[0];
  assign in_ready_o  = inReady_q;
  assign out_data_o  = mainData;

  assign inFire  = fire(in_valid_i, inReady_q);
  assign outFire = fire(state_q[0], out_ready_i);
  assign mainD   = mainFromSkid ? skidData : in_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      inReady_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
    end
  end

  // The skid slot is only written while main is occupied and not draining,
  // so the older beat always leaves through main first.
  always_comb begin
    state_d      = state_q;
    inReady_d    = inReady_q;
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    if (flush_i) begin
      state_d   = ST_EMPTY;
      inReady_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (inFire) begin
            state_d  = ST_BUSY;
            mainLoad = 1'b1;
          end
        end
        ST_BUSY: begin
          if (inFire && outFire) begin
            mainLoad = 1'b1;
          end else if (inFire) begin
            state_d   = ST_FULL;
            skidLoad  = 1'b1;
            inReady_d = 1'b0;
          end else if (outFire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (outFire) begin
            state_d      = ST_BUSY;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            inReady_d    = 1'b1;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          inReady_d = 1'b1;
        end
      endcase
    end
  end

  bb_skid_slot #(.DW(DW), .RST_VAL(RST_VAL)) uMainSlot (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .load_i (mainLoad),
    .d_i    (mainD),
    .q_o    (mainData)
  );

  bb_skid_slot #(.DW(DW), .RST_VAL(RST_VAL)) uSkidSlot (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (flush_i),
    .load_i (skidLoad),
    .d_i    (in_data_i),
    .q_o    (skidData)
  );

endmodule
